// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm : multi-cycle RV32I control sequencer with traps
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control_fsm #(
  parameter bit          ENABLE_UTYPE = 1'b1,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       instr_retired,
  output logic       fault,
  output logic [1:0] fault_cause
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
    S_MEM_WB, S_ALU_WB, S_BRANCH, S_JALR, S_JAL, S_LUI, S_AUIPC, S_FAULT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam bit                TO_EN     = (MEM_TIMEOUT > 0);
  localparam int                CNT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             wait_st;
  logic             timeout;

  // The counter only reaches CNT_LIMIT while stalled, so a late ready still completes.
  assign timeout = TO_EN && !mem_ready && (cnt_q == CNT_LIMIT);

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    wait_st       = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    result_src    = 2'b00;
    imm_src       = 3'b000;
    instr_retired = 1'b0;
    fault         = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        wait_st    = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b010;
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_LUI:             state_d = ENABLE_UTYPE ? S_LUI : S_FAULT;
          OP_AUIPC:           state_d = ENABLE_UTYPE ? S_AUIPC : S_FAULT;
          default:            state_d = S_FAULT;
        endcase
        if (state_d == S_FAULT) cause_d = 2'b01;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
        state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        wait_st  = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          state_d = S_FAULT;
          cause_d = 2'b10;
        end
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        wait_st   = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_d       = S_FETCH;
        end else if (timeout) begin
          state_d = S_FAULT;
          cause_d = 2'b10;
        end
      end
      S_MEM_WB: begin
        reg_write     = 1'b1;
        result_src    = 2'b01;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_ALU_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b10;
        alu_op        = 2'b01;
        pc_write      = branch_taken;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      // JALR computes rs1+imm into ALUOut, then reuses JAL to redirect and link.
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JAL;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src   = 3'b100;
        state_d   = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b100;
        state_d   = S_ALU_WB;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_d       = (TO_EN && wait_st && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;
  assign fault_cause = cause_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: each fetched instruction expands into a list of expected
// control words, consumed one per cycle (wait steps repeat until mem_ready).
`default_nettype none

module tb_multicycle_control_fsm;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, iord;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, fault_cause;
  logic [2:0] imm_src;
  logic       instr_retired, fault;

  logic       rst2_n = 1'b0;
  logic [6:0] op2 = 7'b0110111;
  logic       rdy2 = 1'b0;
  logic       pcw2, irw2, rw2, mr2, mw2, iord2, ret2, fault2;
  logic [1:0] a2, b2, aop2, res2, cause2;
  logic [2:0] imm2;

  multicycle_control_fsm #(.ENABLE_UTYPE(1'b1), .MEM_TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .imm_src(imm_src), .instr_retired(instr_retired),
    .fault(fault), .fault_cause(fault_cause)
  );

  multicycle_control_fsm #(.ENABLE_UTYPE(1'b0), .MEM_TIMEOUT(0)) u_dut_nu (
    .clk(clk), .rst_n(rst2_n), .opcode(op2), .mem_ready(rdy2),
    .branch_taken(1'b0), .pc_write(pcw2), .ir_write(irw2),
    .reg_write(rw2), .mem_read(mr2), .mem_write(mw2), .iord(iord2),
    .alu_src_a(a2), .alu_src_b(b2), .alu_op(aop2),
    .result_src(res2), .imm_src(imm2), .instr_retired(ret2),
    .fault(fault2), .fault_cause(cause2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    else
      n_pass++;
  endtask

  // Control word: {pcw,irw,rw,mr,mw,iord,a[2],b[2],op[2],res[2],imm[3],ret,fault,cause[2]}
  function automatic logic [20:0] act();
    return {pc_write, ir_write, reg_write, mem_read, mem_write, iord, alu_src_a, alu_src_b,
            alu_op, result_src, imm_src, instr_retired, fault, fault_cause};
  endfunction

  function automatic logic [20:0] cw(bit pcw, bit irw, bit rw, bit mr, bit mw, bit io,
                                     logic [1:0] a, logic [1:0] b, logic [1:0] op,
                                     logic [1:0] res, logic [2:0] imm, bit ret);
    return {pcw, irw, rw, mr, mw, io, a, b, op, res, imm, ret, 1'b0, 2'b00};
  endfunction

  typedef struct {
    logic [20:0] w;
    bit wt;       // repeats while mem_ready is low
    bit rdy_pc;   // pc_write/ir_write follow mem_ready (instruction fetch)
    bit br_pc;    // pc_write follows branch_taken
    bit rdy_ret;  // retire follows mem_ready
    bit to_fault; // illegal opcode: trap after this cycle
  } step_t;

  function automatic step_t mk(logic [20:0] w, bit wt, bit rp, bit bp, bit rr, bit tf);
    step_t s;
    s.w = w; s.wt = wt; s.rdy_pc = rp; s.br_pc = bp; s.rdy_ret = rr; s.to_fault = tf;
    return s;
  endfunction

  step_t      q[$];
  bit         m_faulted;
  logic [1:0] m_cause;
  int         m_waits;
  int         m_fault_cycles;

  function automatic step_t st_fetch();
    return mk(cw(0,0,0,1,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,0), 1, 1, 0, 0, 0);
  endfunction

  task automatic model_reset();
    q.delete();
    q.push_back(mk('0, 0, 0, 0, 0, 0));
    q.push_back(st_fetch());
    m_faulted = 0; m_cause = 2'b00; m_waits = 0; m_fault_cycles = 0;
  endtask

  task automatic push_instr(input logic [6:0] op);
    step_t dec, wb;
    dec = mk(cw(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,3'b010,0), 0, 0, 0, 0, 0);
    wb  = mk(cw(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1), 0, 0, 0, 0, 0);
    case (op)
      7'b0110011: begin
        q.push_back(dec);
        q.push_back(mk(cw(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), 0,0,0,0,0));
        q.push_back(wb);
      end
      7'b0010011: begin
        q.push_back(dec);
        q.push_back(mk(cw(0,0,0,0,0,0,2'b10,2'b01,2'b10,2'b00,3'b000,0), 0,0,0,0,0));
        q.push_back(wb);
      end
      7'b0000011: begin
        q.push_back(dec);
        q.push_back(mk(cw(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,3'b000,0), 0,0,0,0,0));
        q.push_back(mk(cw(0,0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1,0,0,0,0));
        q.push_back(mk(cw(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,1), 0,0,0,0,0));
      end
      7'b0100011: begin
        q.push_back(dec);
        q.push_back(mk(cw(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,3'b001,0), 0,0,0,0,0));
        q.push_back(mk(cw(0,0,0,0,1,1,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1,0,0,1,0));
      end
      7'b1100011: begin
        q.push_back(dec);
        q.push_back(mk(cw(0,0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,3'b000,1), 0,0,1,0,0));
      end
      7'b1101111, 7'b1100111: begin
        q.push_back(dec);
        if (op == 7'b1100111)
          q.push_back(mk(cw(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,3'b000,0), 0,0,0,0,0));
        q.push_back(mk(cw(1,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,3'b000,0), 0,0,0,0,0));
        q.push_back(wb);
      end
      7'b0110111, 7'b0010111: begin
        q.push_back(dec);
        q.push_back(mk(cw(0,0,0,0,0,0, (op == 7'b0110111) ? 2'b11 : 2'b01,
                          2'b01,2'b00,2'b00,3'b100,0), 0,0,0,0,0));
        q.push_back(wb);
      end
      default: begin
        dec.to_fault = 1;
        q.push_back(dec);
      end
    endcase
    if (!dec.to_fault) q.push_back(st_fetch());
  endtask

  function automatic logic [20:0] expected(bit r, bit bt);
    logic [20:0] e;
    if (m_faulted) return {18'b0, 1'b1, m_cause};
    e = q[0].w;
    if (q[0].rdy_pc) begin e[20] = r; e[19] = r; end
    if (q[0].br_pc) e[20] = bt;
    if (q[0].rdy_ret) e[3] = r;
    return e;
  endfunction

  task automatic model_step(input bit r, input logic [6:0] op);
    step_t s;
    if (m_faulted) begin m_fault_cycles++; return; end
    s = q[0];
    if (s.wt && !r) begin
      m_waits++;
      if (m_waits == TIMEOUT) begin
        m_faulted = 1; m_cause = 2'b10; q.delete();
      end
      return;
    end
    void'(q.pop_front());
    m_waits = 0;
    if (s.to_fault) begin
      m_faulted = 1; m_cause = 2'b01; q.delete();
    end else if (s.rdy_pc) begin
      push_instr(op);
    end
  endtask

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  logic [6:0] bad_ops [4] = '{7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011};

  initial begin
    bit r, bt;
    int stall_left;
    stall_left = 0;
    model_reset();
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      rst_n = 1'b1;
      if (!m_faulted && q[0].rdy_pc && $urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 19) == 0) opcode = bad_ops[$urandom_range(0, 3)];
        else                            opcode = legal_ops[$urandom_range(0, 8)];
      end
      if (stall_left == 0 && $urandom_range(0, 39) == 0) stall_left = $urandom_range(13, 16);
      if (stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end else begin
        r = ($urandom_range(0, 3) != 0);
      end
      bt = $urandom_range(0, 1) != 0;
      mem_ready    = r;
      branch_taken = bt;
      #1;
      chk(m_faulted ? "fault_word" : "ctrl_word", {11'b0, act()}, {11'b0, expected(r, bt)});
      model_step(r, opcode);
      if ((m_faulted && m_fault_cycles >= 3) || $urandom_range(0, 149) == 0) begin
        #1 rst_n = 1'b0;
        #1 chk("async_reset", {11'b0, act()}, 32'd0);
        model_reset();
      end
    end

    // Second instance: U-type disabled, timeout disabled.
    @(negedge clk);
    rst2_n = 1'b1;
    rdy2   = 1'b0;
    op2    = 7'b0110111;
    for (int i = 0; i < 40; i++) @(negedge clk);
    #1;
    chk("nu_no_timeout", {31'b0, fault2}, 32'd0);
    chk("nu_fetch_wait", {31'b0, mr2}, 32'd1);
    rdy2 = 1'b1;
    #1 chk("nu_fetch_done", {30'b0, irw2, pcw2}, 32'd3);
    @(negedge clk);
    #1 chk("nu_decode", {28'b0, a2, b2}, 32'b0101);
    @(negedge clk);
    #1 chk("nu_illegal_utype", {29'b0, fault2, cause2}, 32'b101);
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1 chk("nu_fault_held", {26'b0, fault2, cause2, rw2, mw2, mr2}, 32'b101000);
    rst2_n = 1'b0;
    #1 chk("nu_fault_clear", {29'b0, fault2, cause2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
